// File: rtl/mini_cpu_p_if.sv
// Host-facing bundle of the mini_cpu_p core: run handshake, programming
// port, debug read port and architectural status.
interface mini_cpu_p_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              run;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [DATA_W-1:0] eax;
    logic [DATA_W-1:0] ebx;
    logic [ADDR_W-1:0] pc;
    logic              carry;
    logic              zero;
    logic              busy;
    logic              halted;

    // Host side: drives requests and programming, observes the core.
    modport master (
        output run, prog_we, prog_addr, prog_data, dbg_addr,
        input  dbg_data, eax, ebx, pc, carry, zero, busy, halted
    );

    // Core side.
    modport slave (
        input  run, prog_we, prog_addr, prog_data, dbg_addr,
        output dbg_data, eax, ebx, pc, carry, zero, busy, halted
    );
endinterface

// File: rtl/mini_cpu_p.sv
// mini_cpu_p: two-register accumulator machine with a unified program/data
// memory, a FETCH/EXEC state machine, run/halt handshake and host port.
// Optional build macro MINI_CPU_SINGLE_STEP_EN: each run pulse executes one
// instruction and the core returns to IDLE (HALT still enters HALT).
module mini_cpu_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic         step,
    input  logic         rst_n,
    mini_cpu_p_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [1:0] OP_MISC  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_ALU   = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    state_t             state;
    logic [DATA_W-1:0]  mem [DEPTH];

    // Instruction register kept as its decoded fields; the ignored middle
    // bits of the word are never stored.
    logic [1:0]         ir_op;
    logic               ir_r;
    logic [ADDR_W-1:0]  ir_a;

    logic [DATA_W-1:0]  eax_q, ebx_q;
    logic [ADDR_W-1:0]  pc_q;
    logic               carry_q, zero_q, busy_q, halted_q;

    logic [DATA_W-1:0]  fetch_word;
    logic [DATA_W-1:0]  dest, src, mem_rd;
    logic [DATA_W:0]    alu_res;
    logic               alu_nop, is_halt, host_ok, st_en;

    // ALU: returns {carry, result}. SUB's top bit is the borrow (dest < src).
    function automatic logic [DATA_W:0] alu_op(input logic [2:0]        sel,
                                               input logic [DATA_W-1:0] d,
                                               input logic [DATA_W-1:0] s);
        logic [DATA_W:0] r;
        case (sel)
            3'd0:    r = {1'b0, d} + {1'b0, s};
            3'd1:    r = {1'b0, d} - {1'b0, s};
            3'd2:    r = {1'b0, d & s};
            3'd3:    r = {1'b0, d | s};
            3'd4:    r = {1'b0, d ^ s};
            default: r = {1'b0, d};
        endcase
        return r;
    endfunction

    assign fetch_word = mem[pc_q];
    assign mem_rd     = mem[ir_a];
    assign dest       = ir_r ? ebx_q : eax_q;
    assign src        = ir_r ? eax_q : ebx_q;
    assign alu_res    = alu_op(ir_a[2:0], dest, src);
    assign alu_nop    = (ir_a[2:0] > 3'd4);
    assign is_halt    = (ir_op == OP_MISC) && !ir_r && (ir_a == {ADDR_W{1'b1}});
    assign host_ok    = (state == S_IDLE) || (state == S_HALT);
    // Reset forces state to IDLE asynchronously, so an in-flight STORE is
    // dropped without needing reset in the memory path.
    assign st_en      = (state == S_EXEC) && (ir_op == OP_STORE);

    // Unified memory: STORE from the core, or host writes while not busy.
    always_ff @(posedge step) begin
        if (st_en)
            mem[ir_a] <= dest;
        else if (host_ok && bus.prog_we)
            mem[bus.prog_addr] <= bus.prog_data;
    end

    // Fetch/execute state machine with registered status outputs.
    always_ff @(posedge step or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ir_op    <= '0;
            ir_r     <= 1'b0;
            ir_a     <= '0;
            eax_q    <= '0;
            ebx_q    <= '0;
            pc_q     <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (bus.run) begin
                        state    <= S_FETCH;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir_op <= fetch_word[DATA_W-1:DATA_W-2];
                    ir_r  <= fetch_word[DATA_W-3];
                    ir_a  <= fetch_word[ADDR_W-1:0];
                    pc_q  <= pc_q + ADDR_W'(1);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (ir_op)
                        OP_MISC: begin
                            if (ir_r)
                                pc_q <= ir_a;
                        end
                        OP_LOAD: begin
                            if (ir_r) ebx_q <= mem_rd;
                            else      eax_q <= mem_rd;
                            zero_q <= (mem_rd == '0);
                        end
                        OP_ALU: begin
                            if (!alu_nop) begin
                                if (ir_r) ebx_q <= alu_res[DATA_W-1:0];
                                else      eax_q <= alu_res[DATA_W-1:0];
                                carry_q <= alu_res[DATA_W];
                                zero_q  <= (alu_res[DATA_W-1:0] == '0);
                            end
                        end
                        default: ;
                    endcase
                    if (is_halt) begin
                        state    <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
`ifdef MINI_CPU_SINGLE_STEP_EN
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
`else
                        state  <= S_FETCH;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.dbg_data = mem[bus.dbg_addr];
    assign bus.eax      = eax_q;
    assign bus.ebx      = ebx_q;
    assign bus.pc       = pc_q;
    assign bus.carry    = carry_q;
    assign bus.zero     = zero_q;
    assign bus.busy     = busy_q;
    assign bus.halted   = halted_q;

endmodule

// File: doc/mini_cpu_p.md
Name: mini_cpu_p

Overview:
Parametrised second-generation mini CPU: accumulator machine with two registers (eax, ebx) and an internal unified program/data memory. Adds a clocked fetch/execute FSM with reset, a run/halt handshake, a host programming port, ALU sub-ops with flags, and JMP/HALT. It sits under the same mini-CPU benches and is the drop-in successor for step-driven simulation.

Parameters:
DATA_W, 8, register/memory word width; must be >= ADDR_W+3
ADDR_W, 5, address width; memory depth 2**ADDR_W words; pc width

Ports:
step  in  1  clock, rising edge active
rst_n  in  1  asynchronous active-low reset
run  in  1  start request; sampled only in IDLE or HALT
prog_we  in  1  host memory write enable
prog_addr  in  ADDR_W  host write address
prog_data  in  DATA_W  host write data
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  mem[dbg_addr], combinational
eax  out  DATA_W  register A
ebx  out  DATA_W  register B
pc  out  ADDR_W  program counter
carry  out  1  carry/borrow flag
zero  out  1  zero flag
busy  out  1  high in FETCH/EXEC
halted  out  1  high in HALT

Behaviour:
- Reset (async, rst_n=0): eax=ebx=0, pc=0, carry=zero=0, IR=0, state=IDLE, busy=0, halted=0. Memory not reset. Reset mid-instruction aborts it; a pending STORE is not written.
- Instruction word: op=IR[DATA_W-1:DATA_W-2], r=IR[DATA_W-3] (0=eax,1=ebx), a=IR[ADDR_W-1:0]; bits between r and a ignored.
- FSM: IDLE -run-> FETCH; FETCH: IR<=mem[pc], pc<=pc+1 (mod 2**ADDR_W) -> EXEC; EXEC: execute IR -> FETCH, or -> HALT on HALT op; HALT -run-> FETCH (resumes at current pc). Two step cycles per instruction.
- op 00: r=1 -> JMP, pc<=a. r=0 and a=all-ones -> HALT (pc stays pointing past HALT). Otherwise NOP.
- op 01 LOAD: reg[r]<=mem[a]; zero<=(mem[a]==0); carry unchanged.
- op 10 ALU: dest=reg[r], src=reg[~r]; a[2:0]: 0 ADD, 1 SUB (dest-src), 2 AND, 3 OR, 4 XOR, 5-7 NOP (flags unchanged). Result truncated to DATA_W. ADD: carry=carry-out; SUB: carry=borrow (dest<src); logic ops: carry<=0. zero=(result==0).
- op 11 STORE: mem[a]<=reg[r] at EXEC edge; flags unchanged.
- Data words in instruction stream are executed as instructions (no operand skip).
- prog_we honoured only in IDLE or HALT; ignored (no write) in FETCH/EXEC. prog_we and run same cycle in IDLE: write occurs and FSM enters FETCH; fetch of that address on the next edge sees the new data.
- run while busy ignored. STORE to the address at pc: the next FETCH sees the stored value.
- dbg_data is a combinational memory read, valid in all states, including during reset.

Optional Feature:
MINI_CPU_SINGLE_STEP_EN: when defined, EXEC of a non-HALT instruction returns to IDLE instead of FETCH, so each run pulse executes exactly one instruction; HALT still enters HALT. When undefined, the core free-runs from FETCH until HALT as above.

Test Plan:
- Reset: drive rst_n=0 mid-EXEC of a STORE -> all outputs zero, state IDLE, target memory word unchanged.
- Program (ADDR_W=5) mem[0..5]=0x41,0x05,0x61,0x80,0xC2,0x1F; pulse run -> eax=10, ebx=5, mem[2]=10 via dbg, carry=0, zero=0, halted=1 after 12 cycles from first FETCH, pc=6.
- ALU overflow/SUB: eax=0xF0, ebx=0x20; ADD -> eax=0x10, carry=1. Then eax=0x05, ebx=0x07; SUB -> eax=0xFE, carry=1. Then eax=0x07, ebx=0x07; XOR -> eax=0, zero=1, carry=0.
- JMP/wrap: mem[31]=0x00 (NOP), pc reaches 31 -> pc wraps to 0. mem[0]=0x23 (JMP 3) -> pc=3 after EXEC.
- prog_we while busy -> memory unchanged. prog_we in HALT -> write lands. run in HALT -> resumes at pc.
- With MINI_CPU_SINGLE_STEP_EN: each run pulse advances exactly one instruction; 5 pulses on the program above -> eax=10, ebx=5, mem[2]=10, halted=0.
